ipg_tx_sched: RTL and testbench

- Scheduler that shares the TX inter-packet-gap (IPG) side channel between several message sources (read replies, write requests, debug).
- Picks one requester per message (round-robin) and buffers its header and 64-bit data words.
- Slices that byte stream into IPG slots of whatever size the PHY offers each cycle.
- Sits between the memory-request/reply logic and the PHY TX IPG insertion point. Its chunk format is the one the RX IPG processor parses.

---
 rtl/ipg_pkg.sv | 25 ++
 rtl/ipg_byte_fifo.sv | 50 +++++
 rtl/ipg_tx_sched.sv | 195 +++++++++++++++++++
 tb/tb_ipg_tx_sched.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipg_pkg.sv
// Shared IPG side-channel definitions: marker layout, slot limits, scheduler
// state encoding and header opcodes common to the TX scheduler and RX parser.
package ipg_pkg;

    localparam int IPG_HDR_WIDTH      = 8;
    localparam int IPG_MAX_SLOT_BYTES = 7;
    localparam int IPG_FIFO_BYTES     = 16;

    localparam int IPG_MRK_SOM = 0;
    localparam int IPG_MRK_EOM = 1;

    // Header opcode lives in the top two bits of the header byte.
    localparam int         IPG_HDR_OP_LSB    = 6;
    localparam logic [1:0] IPG_HDR_OP_RD_REQ = 2'd0;
    localparam logic [1:0] IPG_HDR_OP_WR_REQ = 2'd1;
    localparam logic [1:0] IPG_HDR_OP_RD_RPL = 2'd2;
    localparam logic [1:0] IPG_HDR_OP_DEBUG  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } ipg_state_e;

endpackage

// File: rtl/ipg_byte_fifo.sv
// 16-byte shifting FIFO: pops 0..7 bytes from the head and appends 0..9 bytes
// after whatever remains, all in one cycle.
module ipg_byte_fifo
    import ipg_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [3:0]                      push_n_i,
    input  logic [71:0]                     push_data_i,
    input  logic [2:0]                      pop_n_i,
    output logic [8*IPG_MAX_SLOT_BYTES-1:0] head_o,
    output logic [4:0]                      count_o
);

    logic [IPG_FIFO_BYTES-1:0][7:0] buf_q, buf_d;
    logic [4:0]                     count_q, count_d;
    int                             rem;
    int                             src;

    // Bytes past the new count are forced to zero so nothing stale survives.
    always_comb begin
        buf_d = '0;
        rem   = int'(count_q) - int'(pop_n_i);
        src   = 0;
        for (int i = 0; i < IPG_FIFO_BYTES; i++) begin
            if (i < rem) begin
                src      = i + int'(pop_n_i);
                buf_d[i] = buf_q[src[3:0]];
            end else if ((i - rem) < int'(push_n_i)) begin
                src      = i - rem;
                buf_d[i] = push_data_i[8*src +: 8];
            end
        end
        count_d = count_q - 5'(pop_n_i) + 5'(push_n_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q   <= '0;
            count_q <= '0;
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
        end
    end

    assign head_o  = buf_q[IPG_MAX_SLOT_BYTES-1:0];
    assign count_o = count_q;

endmodule

// File: rtl/ipg_tx_sched.sv
// Round-robin scheduler that packs one requester's message at a time into the
// TX IPG side channel, slicing the byte stream to each offered slot.
//
// state | meaning
// IDLE  | buffer empty, waiting for any requester
// LOAD  | message granted, accepting further words from the owner
// DRAIN | last word taken, emptying the buffer into slots
module ipg_tx_sched
    import ipg_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = 64,
    parameter int HDR_WIDTH      = 8,
    parameter int MAX_SLOT_BYTES = 7
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*HDR_WIDTH-1:0]  req_hdr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          slot_valid,
    input  logic [2:0]                    slot_cap,
    output logic                          tx_ipg_valid,
    output logic [63:0]                   tx_ipg_data,
    output logic [5:0]                    tx_ipg_len,
    output logic                          busy,
    output logic [1:0]                    grant_idx
);

    ipg_state_e                        state_q, state_d;
    logic [1:0]                        grant_q, grant_d;
    logic [1:0]                        rr_q, rr_d;
    logic                              som_pend_q, som_pend_d;
    logic                              tx_valid_q, tx_valid_d;
    logic [63:0]                       tx_data_q, tx_data_d;
    logic [5:0]                        tx_len_q, tx_len_d;

    logic [4:0]                        count;
    logic [4:0]                        remain;
    logic [8*IPG_MAX_SLOT_BYTES-1:0]   head;
    logic [2:0]                        cap_lim;
    logic [2:0]                        pop_n;
    logic [3:0]                        push_n;
    logic [DATA_WIDTH+HDR_WIDTH-1:0]   push_data;
    logic [NUM_REQ-1:0]                ready_int;

    logic [1:0]                        pick;
    logic                              pick_found;
    int                                pick_pos;
    logic [1:0]                        sel;
    logic [NUM_REQ-1:0]                sel_oh;
    logic [DATA_WIDTH-1:0]             sel_data;
    logic [HDR_WIDTH-1:0]              sel_hdr;
    logic                              sel_valid;
    logic                              sel_last;

    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        pick_pos   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pick_pos = (int'(rr_q) + k) % NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pick_found && (i == pick_pos) && req_valid[i]) begin
                    pick       = 2'(i);
                    pick_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel      = (state_q == ST_IDLE) ? pick : grant_q;
        sel_data = '0;
        sel_hdr  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_oh[i] = (i == int'(sel));
            if (i == int'(sel)) begin
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_hdr  = req_hdr[i*HDR_WIDTH +: HDR_WIDTH];
            end
        end
        sel_valid = |(req_valid & sel_oh);
        sel_last  = |(req_last & sel_oh);
    end

    always_comb begin
        cap_lim = (int'(slot_cap) > MAX_SLOT_BYTES) ? 3'(MAX_SLOT_BYTES) : slot_cap;
        pop_n   = 3'd0;
        if (slot_valid && (cap_lim != 3'd0) && (count != 5'd0)) begin
            pop_n = (count < 5'(cap_lim)) ? count[2:0] : cap_lim;
        end
        remain = count - 5'(pop_n);
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        som_pend_d = som_pend_q;
        push_n     = 4'd0;
        push_data  = '0;
        ready_int  = '0;

        if (pop_n != 3'd0) begin
            som_pend_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_found && (count == 5'd0)) begin
                    grant_d    = pick;
                    ready_int  = sel_oh;
                    push_n     = 4'd9;
                    push_data  = {sel_data, sel_hdr};
                    som_pend_d = 1'b1;
                    rr_d       = (int'(pick) == NUM_REQ - 1) ? 2'd0 : pick + 2'd1;
                    state_d    = sel_last ? ST_DRAIN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Room check uses the count left after this cycle's pop.
                if (sel_valid && (remain <= 5'd8)) begin
                    ready_int = sel_oh;
                    push_n    = 4'd8;
                    push_data = {{HDR_WIDTH{1'b0}}, sel_data};
                    if (sel_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (remain == 5'd0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_valid_d = (pop_n != 3'd0);
        tx_len_d   = {pop_n, 3'b000};
        tx_data_d  = '0;
        for (int i = 1; i <= IPG_MAX_SLOT_BYTES; i++) begin
            if (i <= int'(pop_n)) begin
                tx_data_d[8*i +: 8] = head[8*(i-1) +: 8];
            end
        end
        tx_data_d[IPG_MRK_SOM] = som_pend_q && (pop_n != 3'd0);
        tx_data_d[IPG_MRK_EOM] = (state_q == ST_DRAIN) && (pop_n != 3'd0) &&
                                 ({2'b00, pop_n} == count);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_q       <= '0;
            som_pend_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_len_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            som_pend_q <= som_pend_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_len_q   <= tx_len_d;
        end
    end

    ipg_byte_fifo u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_n_i    (push_n),
        .push_data_i (push_data),
        .pop_n_i     (pop_n),
        .head_o      (head),
        .count_o     (count)
    );

    // Ready is combinational, so hold it low while reset is asserted.
    assign req_ready    = ready_int & {NUM_REQ{rst_n}};
    assign busy         = (state_q != ST_IDLE) || (count != 5'd0);
    assign grant_idx    = grant_q;
    assign tx_ipg_valid = tx_valid_q;
    assign tx_ipg_data  = tx_data_q;
    assign tx_ipg_len   = tx_len_q;

endmodule

// File: tb/tb_ipg_tx_sched.sv
// Directed bench for ipg_tx_sched: byte-stream scoreboard with expected chunk
// lengths, plus grant-order, backpressure-timing and reset checks.
module tb_ipg_tx_sched;

    localparam int NR = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*8-1:0]   req_hdr;
    logic [NR*64-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              slot_valid;
    logic [2:0]        slot_cap;
    logic              tx_ipg_valid;
    logic [63:0]       tx_ipg_data;
    logic [5:0]        tx_ipg_len;
    logic              busy;
    logic [1:0]        grant_idx;

    ipg_tx_sched #(.NUM_REQ(NR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_hdr      (req_hdr),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .slot_valid   (slot_valid),
        .slot_cap     (slot_cap),
        .tx_ipg_valid (tx_ipg_valid),
        .tx_ipg_data  (tx_ipg_data),
        .tx_ipg_len   (tx_ipg_len),
        .busy         (busy),
        .grant_idx    (grant_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  hdr;
        logic [63:0] data;
        logic        last;
        logic        first;
    } word_t;

    typedef struct {
        logic [7:0] b;
        logic       som;
        logic       eom;
    } sbe_t;

    word_t       wq0[$];
    word_t       wq1[$];
    sbe_t        sb_q[$];
    int          len_q[$];
    logic [63:0] chunk_log[$];
    int          hs0[$];
    int          hs1[$];
    int          grant_log[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc      = 0;

    int          m_len;
    logic [63:0] m_exp;
    sbe_t        m_e;
    logic [63:0] go;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_msg(input int r, input logic [7:0] hdr, input int nw,
                            input logic [63:0] base, input bit to_sb);
        sbe_t e;
        if (to_sb) begin
            e.b = hdr; e.som = 1'b1; e.eom = 1'b0;
            sb_q.push_back(e);
        end
        for (int k = 0; k < nw; k++) begin
            word_t w;
            w.hdr   = hdr;
            w.data  = base + 64'(k) * 64'h0101010101010101;
            w.last  = (k == nw - 1);
            w.first = (k == 0);
            if (r == 0) wq0.push_back(w);
            else        wq1.push_back(w);
            if (to_sb) begin
                for (int j = 0; j < 8; j++) begin
                    e.b   = w.data[8*j +: 8];
                    e.som = 1'b0;
                    e.eom = (k == nw - 1) && (j == 7);
                    sb_q.push_back(e);
                end
            end
        end
    endtask

    task automatic push_lens(input int total, input int cap);
        int t;
        int n;
        t = total;
        while (t > 0) begin
            n = (t < cap) ? t : cap;
            len_q.push_back(8 * n);
            t -= n;
        end
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int c;
        c = 0;
        while (c < maxc && !(sb_q.size() == 0 && len_q.size() == 0 && wq0.size() == 0 &&
                             wq1.size() == 0 && busy === 1'b0)) begin
            @(negedge clk);
            c++;
        end
        check(tag, 64'(c < maxc), 64'd1);
    endtask

    task automatic wait_hs0(input string tag, input int n, input int maxc);
        int c;
        c = 0;
        while (c < maxc && hs0.size() < n) begin
            @(negedge clk);
            #2;
            c++;
        end
        check(tag, 64'(c < maxc), 64'd1);
    endtask

    // Requester driver: present queue heads at negedge, retire on handshake.
    initial begin
        req_valid = '0;
        req_last  = '0;
        req_hdr   = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            if (wq0.size() > 0) begin
                req_valid[0]   = 1'b1;
                req_hdr[7:0]   = wq0[0].hdr;
                req_data[63:0] = wq0[0].data;
                req_last[0]    = wq0[0].last;
            end else begin
                req_valid[0] = 1'b0;
                req_last[0]  = 1'b0;
            end
            if (wq1.size() > 0) begin
                req_valid[1]     = 1'b1;
                req_hdr[15:8]    = wq1[0].hdr;
                req_data[127:64] = wq1[0].data;
                req_last[1]      = wq1[0].last;
            end else begin
                req_valid[1] = 1'b0;
                req_last[1]  = 1'b0;
            end
            #1;
            if (req_valid[0] && req_ready[0] === 1'b1 && wq0.size() > 0) begin
                hs0.push_back(cyc);
                if (wq0[0].first) grant_log.push_back(0);
                void'(wq0.pop_front());
            end
            if (req_valid[1] && req_ready[1] === 1'b1 && wq1.size() > 0) begin
                hs1.push_back(cyc);
                if (wq1[0].first) grant_log.push_back(1);
                void'(wq1.pop_front());
            end
        end
    end

    // Chunk monitor: each chunk consumes its expected length from the byte scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && tx_ipg_valid === 1'b1) begin
            chunk_log.push_back(tx_ipg_data);
            check("chunk_expected", 64'(len_q.size() != 0), 64'd1);
            if (len_q.size() != 0) begin
                m_len = len_q.pop_front();
                check("chunk_len", 64'(tx_ipg_len), 64'(m_len));
                m_exp = '0;
                for (int i = 0; i < m_len / 8; i++) begin
                    if (sb_q.size() != 0) begin
                        m_e = sb_q.pop_front();
                        m_exp[8*(i+1) +: 8] = m_e.b;
                        if (m_e.som) m_exp[0] = 1'b1;
                        if (m_e.eom) m_exp[1] = 1'b1;
                    end
                end
                check("chunk_data", tx_ipg_data, m_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        slot_valid = 1'b0;
        slot_cap   = 3'd0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_tx_valid", 64'(tx_ipg_valid), 64'd0);
        check("rst_tx_data",  tx_ipg_data,       64'd0);
        check("rst_tx_len",   64'(tx_ipg_len),   64'd0);
        check("rst_busy",     64'(busy),         64'd0);
        check("rst_grant",    64'(grant_idx),    64'd0);
        check("rst_ready",    64'(req_ready),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin between two requesters with one-word messages
        slot_valid = 1'b1;
        slot_cap   = 3'd7;
        grant_log.delete();
        send_msg(0, 8'h10, 1, 64'h0102030405060708, 1'b1);
        send_msg(1, 8'h20, 1, 64'hA1A2A3A4A5A6A7A8, 1'b1);
        send_msg(0, 8'h10, 1, 64'h1112131415161718, 1'b1);
        send_msg(1, 8'h20, 1, 64'hB1B2B3B4B5B6B7B8, 1'b1);
        repeat (4) push_lens(9, 7);
        wait_idle("rr_done", 200);
        check("rr_count", 64'(grant_log.size()), 64'd4);
        go = '0;
        foreach (grant_log[i]) go = (go << 4) | 64'(grant_log[i]);
        check("rr_order", go, 64'h0101);
        check("rr_grant_idx", 64'(grant_idx), 64'd1);

        // Single message, full-width slots
        chunk_log.delete();
        send_msg(0, 8'hA5, 1, 64'h1122334455667788, 1'b1);
        push_lens(9, 7);
        wait_idle("single_done", 100);
        check("single_chunks", 64'(chunk_log.size()), 64'd2);
        if (chunk_log.size() >= 2) begin
            check("single_chunk1", chunk_log[0], 64'h334455667788A501);
            check("single_chunk2", chunk_log[1], 64'h0000000000112202);
        end
        check("single_busy", 64'(busy), 64'd0);
        check("single_grant_idx", 64'(grant_idx), 64'd0);

        // Backpressure: three words through 3-byte slots
        slot_cap = 3'd3;
        hs0.delete();
        chunk_log.delete();
        send_msg(0, 8'hC3, 3, 64'h0F0E0D0C0B0A0908, 1'b1);
        push_lens(25, 3);
        wait_idle("bp_done", 200);
        check("bp_words", 64'(hs0.size()), 64'd3);
        if (hs0.size() == 3) begin
            check("bp_gap1", 64'(hs0[1] - hs0[0]), 64'd1);
            check("bp_gap2", 64'(hs0[2] - hs0[1]), 64'd2);
        end
        check("bp_chunks", 64'(chunk_log.size()), 64'd9);

        // Zero-capacity and absent slots hold a loaded buffer
        slot_valid = 1'b0;
        slot_cap   = 3'd7;
        hs0.delete();
        chunk_log.delete();
        send_msg(0, 8'h5A, 1, 64'hDEADBEEFCAFEF00D, 1'b1);
        push_lens(9, 7);
        wait_hs0("zc_grant", 1, 50);
        @(negedge clk);
        slot_valid = 1'b1;
        slot_cap   = 3'd0;
        @(negedge clk);
        @(negedge clk);
        slot_valid = 1'b0;
        slot_cap   = 3'd7;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("zc_no_chunks", 64'(chunk_log.size()), 64'd0);
        check("zc_tx_valid",  64'(tx_ipg_valid),     64'd0);
        check("zc_busy",      64'(busy),             64'd1);
        slot_valid = 1'b1;
        wait_idle("zc_done", 100);

        // Reset after the first of three words
        slot_valid = 1'b0;
        hs0.delete();
        send_msg(0, 8'h77, 3, 64'h7071727374757677, 1'b0);
        wait_hs0("rst_first_word", 1, 50);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready",    64'(req_ready),    64'd0);
        check("mid_rst_busy",     64'(busy),         64'd0);
        check("mid_rst_tx_valid", 64'(tx_ipg_valid), 64'd0);
        check("mid_rst_tx_data",  tx_ipg_data,       64'd0);
        check("mid_rst_grant",    64'(grant_idx),    64'd0);
        wq0.delete();
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        slot_valid = 1'b1;
        slot_cap   = 3'd7;
        chunk_log.delete();
        send_msg(1, 8'h99, 1, 64'h8182838485868788, 1'b1);
        push_lens(9, 7);
        wait_idle("post_rst_done", 100);
        check("post_rst_grant", 64'(grant_idx), 64'd1);
        check("post_rst_req0_hs", 64'(hs0.size()), 64'd1);
        if (chunk_log.size() > 0) begin
            check("post_rst_som", 64'(chunk_log[0][7:0]), 64'h01);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
